gptp_sync_tx: RTL

//   gPTP two-step master transmit engine on the clk_sd domain. Emits periodic 352-bit Sync frames on the

---
 rtl/gptp_sync_tx.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/gptp_sync_tx.sv
// gPTP two-step master transmit engine: periodic Sync, t1 capture, matching Follow_Up.
module gptp_sync_tx #(
  parameter int unsigned SYNC_INTERVAL = 125000,
  parameter int unsigned TS_TIMEOUT    = 1024
) (
  input  logic          clk_sd,
  input  logic          reset,
  input  logic          enable,
  input  logic [63:0]   clock_identity,
  input  logic [15:0]   port_number,
  input  logic [7:0]    domain_number,
  input  logic [7:0]    log_interval,
  output logic [351:0]  tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  input  logic          ts_valid,
  input  logic [79:0]   ts_data,
  output logic [79:0]   t1_ts,
  output logic [15:0]   seq_id,
  output logic          sync_done,
  output logic          ts_timeout,
  output logic [15:0]   overrun_cnt,
  output logic          busy
);

  localparam int unsigned TW = $clog2(SYNC_INTERVAL);
  localparam int unsigned CW = $clog2(TS_TIMEOUT);
  localparam logic [TW-1:0] TIMER_LAST = TW'(SYNC_INTERVAL - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(TS_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SEND_SYNC, WAIT_TS, SEND_FU} state_t;

  state_t         state_q, state_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic           pending_q, pending_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [351:0]   tx_data_q, tx_data_d;
  logic           tx_valid_q, tx_valid_d;
  logic [79:0]    t1_ts_q, t1_ts_d;
  logic [15:0]    seq_id_q, seq_id_d;
  logic           sync_done_q, sync_done_d;
  logic           ts_timeout_q, ts_timeout_d;
  logic [15:0]    overrun_q, overrun_d;

  logic tick;
  logic consume;

  assign tick    = enable && (timer_q == TIMER_LAST);
  assign consume = (state_q == IDLE) && pending_q;

  // 44-byte big-endian frame; Follow_Up differs in msgType, flags, control and body.
  function automatic logic [351:0] build_frame(input logic is_fu, input logic [7:0] dom,
                                               input logic [63:0] cid, input logic [15:0] port,
                                               input logic [15:0] seq, input logic [7:0] log_int,
                                               input logic [79:0] ts);
    return {4'h1, (is_fu ? 4'h8 : 4'h0), 8'h02, 16'd44, dom, 8'h00,
            (is_fu ? 16'h0008 : 16'h0208), 96'h0, cid, port, seq,
            (is_fu ? 8'h02 : 8'h00), log_int, (is_fu ? ts : 80'h0)};
  endfunction

  // Interval timer, pending/overrun tracking and exchange sequencing.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    pending_d    = pending_q;
    cnt_d        = cnt_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    t1_ts_d      = t1_ts_q;
    seq_id_d     = seq_id_q;
    sync_done_d  = 1'b0;
    ts_timeout_d = 1'b0;
    overrun_d    = overrun_q;

    if (!enable) begin
      timer_d   = '0;
      pending_d = 1'b0;
    end else begin
      timer_d   = tick ? '0 : timer_q + 1'b1;
      // a tick landing on the consume cycle re-arms pending instead of counting as lost
      pending_d = tick | (pending_q & ~consume);
      if (tick && pending_q && !consume && (overrun_q != 16'hFFFF)) begin
        overrun_d = overrun_q + 16'd1;
      end
    end

    unique case (state_q)
      IDLE: begin
        if (pending_q) begin
          tx_data_d  = build_frame(1'b0, domain_number, clock_identity, port_number,
                                   seq_id_q, log_interval, 80'h0);
          tx_valid_d = 1'b1;
          state_d    = SEND_SYNC;
        end
      end
      SEND_SYNC: begin
        if (tx_ready) begin
          tx_valid_d = 1'b0;
          cnt_d      = '0;
          state_d    = WAIT_TS;
        end
      end
      WAIT_TS: begin
        if (ts_valid) begin
          t1_ts_d    = ts_data;
          tx_data_d  = build_frame(1'b1, domain_number, clock_identity, port_number,
                                   seq_id_q, log_interval, ts_data);
          tx_valid_d = 1'b1;
          state_d    = SEND_FU;
        end else if (cnt_q == CNT_LAST) begin
          ts_timeout_d = 1'b1;
          seq_id_d     = seq_id_q + 16'd1;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SEND_FU: begin
        if (tx_ready) begin
          tx_valid_d  = 1'b0;
          sync_done_d = 1'b1;
          seq_id_d    = seq_id_q + 16'd1;
          state_d     = IDLE;
        end
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_sd) begin
    if (!reset) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      pending_q    <= 1'b0;
      cnt_q        <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      t1_ts_q      <= '0;
      seq_id_q     <= '0;
      sync_done_q  <= 1'b0;
      ts_timeout_q <= 1'b0;
      overrun_q    <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      pending_q    <= pending_d;
      cnt_q        <= cnt_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      t1_ts_q      <= t1_ts_d;
      seq_id_q     <= seq_id_d;
      sync_done_q  <= sync_done_d;
      ts_timeout_q <= ts_timeout_d;
      overrun_q    <= overrun_d;
    end
  end

  assign tx_data     = tx_data_q;
  assign tx_valid    = tx_valid_q;
  assign t1_ts       = t1_ts_q;
  assign seq_id      = seq_id_q;
  assign sync_done   = sync_done_q;
  assign ts_timeout  = ts_timeout_q;
  assign overrun_cnt = overrun_q;
  assign busy        = (state_q != IDLE);

endmodule
